pipe_stage_reg: RTL

//   Parametrised elastic pipeline-stage register (successor of the fixed IF/ID latch) carrying PC, PC+step and a payload.

---
 rtl/pipe_stage_reg_pkg.sv | 16 +
 rtl/pipe_stage_reg_if.sv | 22 ++
 rtl/pipe_stage_reg_entry.sv | 41 ++++
 rtl/pipe_stage_reg.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_reg_pkg.sv
// cpu_pipe_pkg: shared constants and stage FSM encoding
// for the elastic pipeline-stage register.
package cpu_pipe_pkg;

  localparam logic [31:0] CPU_RESET_PC = 32'h0000_3000;
  localparam int          CPU_PC_STEP  = 4;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] BUBBLE_DEF   = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_HALF  = 2'b01,
    ST_FULL  = 2'b10
  } stage_st_e;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// pipe_stage_reg_if: valid/ready beat bus carrying pc, pc_next, data.
// master drives valid/pc/pc_next/data and samples ready; slave is the mirror.
interface pipe_stage_reg_if #(
  parameter int PC_W   = 32,
  parameter int DATA_W = 32
);
  logic              valid;
  logic              ready;
  logic [PC_W-1:0]   pc;
  logic [PC_W-1:0]   pc_next;
  logic [DATA_W-1:0] data;

  modport master (
    output valid, pc, pc_next, data,
    input  ready
  );

  modport slave (
    input  valid, pc, pc_next, data,
    output ready
  );
endinterface

// File: rtl/pipe_stage_reg_entry.sv
// pipe_stage_entry: one {valid,pc,pc_next,data} slot with load/clear.
// Ports: clk, reset (async active-low), load, clr, d_* in, q_* out.
// load wins over clr; clr drops valid, parks data at BUBBLE, keeps pc.
module pipe_stage_entry #(
  parameter int                PC_W        = 32,
  parameter int                DATA_W      = 32,
  parameter logic [PC_W-1:0]   RST_PC      = '0,
  parameter logic [PC_W-1:0]   RST_PC_NEXT = '0,
  parameter logic [DATA_W-1:0] BUBBLE      = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clr,
  input  logic [PC_W-1:0]   d_pc,
  input  logic [PC_W-1:0]   d_pc_next,
  input  logic [DATA_W-1:0] d_data,
  output logic              q_valid,
  output logic [PC_W-1:0]   q_pc,
  output logic [PC_W-1:0]   q_pc_next,
  output logic [DATA_W-1:0] q_data
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_valid   <= 1'b0;
      q_pc      <= RST_PC;
      q_pc_next <= RST_PC_NEXT;
      q_data    <= BUBBLE;
    end else if (load) begin
      q_valid   <= 1'b1;
      q_pc      <= d_pc;
      q_pc_next <= d_pc_next;
      q_data    <= d_data;
    end else if (clr) begin
      q_valid   <= 1'b0;
      q_data    <= BUBBLE;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic stage register, MAIN + SKID entries, registered
// in_ready, synchronous flush.
// Ports: clk, reset (async active-low), flush, up (slave beat bus),
// dn (master beat bus); stall_cnt/bubble_cnt when PIPE_STAGE_PERF_EN.
module pipe_stage_reg
  import cpu_pipe_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                PC_W     = 32,
  parameter logic [PC_W-1:0]   RESET_PC = PC_W'(CPU_RESET_PC),
  parameter int                PC_STEP  = CPU_PC_STEP,
  parameter logic [DATA_W-1:0] BUBBLE   = DATA_W'(BUBBLE_DEF),
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  pipe_stage_reg_if.slave   up,
  pipe_stage_reg_if.master  dn
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  localparam logic [PC_W-1:0] RST_NXT =
    RESET_PC + PC_W'(PC_STEP);

  stage_st_e st, st_n;
  logic      in_ready_q;

  logic              m_valid, s_valid;
  logic [PC_W-1:0]   m_pc, m_pc_next;
  logic [PC_W-1:0]   s_pc, s_pc_next;
  logic [DATA_W-1:0] m_data, s_data;

  logic              ld_main, ld_skid;
  logic              clr_main, clr_skid;
  logic              sel_skid;
  logic [PC_W-1:0]   md_pc, md_pc_next;
  logic [DATA_W-1:0] md_data;

  logic accept, send;

  assign accept = up.valid && in_ready_q;
  assign send   = m_valid && dn.ready;

  // MAIN refills from SKID only when draining FULL
  assign sel_skid   = (st == ST_FULL) && s_valid;
  assign md_pc      = sel_skid ? s_pc      : up.pc;
  assign md_pc_next = sel_skid ? s_pc_next : up.pc_next;
  assign md_data    = sel_skid ? s_data    : up.data;

  always_comb begin
    st_n     = st;
    ld_main  = 1'b0;
    ld_skid  = 1'b0;
    clr_main = 1'b0;
    clr_skid = 1'b0;
    unique case (st)
      ST_EMPTY: begin
        if (accept) begin
          ld_main = 1'b1;
          st_n    = ST_HALF;
        end
      end
      ST_HALF: begin
        priority case (1'b1)
          accept && send: ld_main = 1'b1;
          send: begin
            clr_main = 1'b1;
            st_n     = ST_EMPTY;
          end
          accept: begin
            ld_skid = 1'b1;
            st_n    = ST_FULL;
          end
          default: ;
        endcase
      end
      ST_FULL: begin
        if (send) begin
          ld_main  = 1'b1;
          clr_skid = 1'b1;
          st_n     = ST_HALF;
        end
      end
      default: begin
        clr_main = 1'b1;
        clr_skid = 1'b1;
        st_n     = ST_EMPTY;
      end
    endcase
    // flush drops everything held and anything arriving
    if (flush) begin
      ld_main  = 1'b0;
      ld_skid  = 1'b0;
      clr_main = 1'b1;
      clr_skid = 1'b1;
      st_n     = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st         <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      st         <= st_n;
      in_ready_q <= (st_n != ST_FULL);
    end
  end

  pipe_stage_entry #(
    .PC_W        (PC_W),
    .DATA_W      (DATA_W),
    .RST_PC      (RESET_PC),
    .RST_PC_NEXT (RST_NXT),
    .BUBBLE      (BUBBLE)
  ) u_main (
    .clk       (clk),
    .reset     (reset),
    .load      (ld_main),
    .clr       (clr_main),
    .d_pc      (md_pc),
    .d_pc_next (md_pc_next),
    .d_data    (md_data),
    .q_valid   (m_valid),
    .q_pc      (m_pc),
    .q_pc_next (m_pc_next),
    .q_data    (m_data)
  );

  pipe_stage_entry #(
    .PC_W        (PC_W),
    .DATA_W      (DATA_W),
    .RST_PC      (RESET_PC),
    .RST_PC_NEXT (RST_NXT),
    .BUBBLE      (BUBBLE)
  ) u_skid (
    .clk       (clk),
    .reset     (reset),
    .load      (ld_skid),
    .clr       (clr_skid),
    .d_pc      (up.pc),
    .d_pc_next (up.pc_next),
    .d_data    (up.data),
    .q_valid   (s_valid),
    .q_pc      (s_pc),
    .q_pc_next (s_pc_next),
    .q_data    (s_data)
  );

  assign up.ready   = in_ready_q;
  assign dn.valid   = m_valid;
  assign dn.pc      = m_pc;
  assign dn.pc_next = m_pc_next;
  assign dn.data    = m_data;

`ifdef PIPE_STAGE_PERF_EN
  // saturating; only reset clears them
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (m_valid && !dn.ready && !(&stall_cnt))
        stall_cnt <= stall_cnt + 1'b1;
      if (!m_valid && !(&bubble_cnt))
        bubble_cnt <= bubble_cnt + 1'b1;
    end
  end
`endif

endmodule
